// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Byte FIFO feeding an 8N1 serializer for the UART transmit path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH        = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_fifo_write_en,
    input  logic [7:0]               uart_fifo_data,
    output logic                     tx_line,
    output logic                     tx_ready,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_overflow
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_BAUD_W-1:0]   w_baud_nxt;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_bit_nxt;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  w_pop;

    logic [7:0]            r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_ovf;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_bit_end;
    logic [7:0]            w_head;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign w_push    = uart_fifo_write_en && (!w_full || w_pop);
    assign w_bit_end = (r_baud == c_BAUD_LAST);
    assign w_head    = r_mem[r_rd_ptr];

    assign tx_line     = r_tx;
    assign tx_ready    = !w_full;
    assign tx_busy     = (r_state != ST_IDLE);
    assign tx_count    = r_count;
    assign tx_overflow = r_ovf;

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit_idx + 3'd1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when more data waits
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = ST_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_ovf     <= uart_fifo_write_en && !w_push;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; pointers and count define which entries are valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= uart_fifo_data;
        end
    end

endmodule

`default_nettype wire
